// File: rtl/mem_pkg.sv
// Shared memory-interface definitions: responder state encoding and the default
// bus/latency sizes used by the control unit, the datapath and mem_responder.
package mem_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LATENCY = 2;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_RESPOND  = 2'd2,
    ST_WAIT_REL = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM, 2^ADDR_W x DATA_W, with a registered read port.
// Only the read register is cleared by reset; the stored words survive reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // The read register holds its value between reads so the last result stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: latches a mem_read/mem_write request, waits LATENCY cycles,
// performs the access and pulses mem_ready in cycle LATENCY+1 after acceptance.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              req_err
);

  mem_state_t        state;
  mem_state_t        state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_write_q;

  logic any_req;
  logic both_req;
  logic accept;
  logic fire;
  logic arr_we;
  logic arr_re;

  assign any_req  = mem_read | mem_write;
  assign both_req = mem_read & mem_write;
  assign accept   = (state == ST_IDLE) && any_req && !both_req;
  assign fire     = (state == ST_ACCESS) && (wait_cnt == '0);

  // A reset on the final ACCESS edge must not commit the pending write.
  assign arr_we = fire && is_write_q && !reset;
  assign arr_re = fire && !is_write_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      req_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      req_err  <= (state == ST_IDLE) && both_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else if (accept) begin
      addr_q     <= addr;
      wdata_q    <= wdata;
      is_write_q <= mem_write;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (both_req) begin
          state_nxt = ST_WAIT_REL;
        end else if (any_req) begin
          state_nxt    = ST_ACCESS;
          wait_cnt_nxt = CNT_W'(LATENCY - 1);
        end
      end
      ST_ACCESS: begin
        if (wait_cnt == '0) begin
          state_nxt = ST_RESPOND;
        end else begin
          wait_cnt_nxt = wait_cnt - CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        state_nxt = any_req ? ST_WAIT_REL : ST_IDLE;
      end
      ST_WAIT_REL: begin
        // Hold here until the strobe drops so one request is served exactly once.
        if (!any_req) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mem_ready = (state == ST_RESPOND);
  assign busy      = (state != ST_IDLE);

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY 2, 1 and 4 instances side by side.
module tb_mem_responder;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [15:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       rd;
  logic [2:0]       wr;
  logic [2:0][7:0]  ad;
  logic [2:0][15:0] wd;
  logic [2:0][15:0] rdt;
  logic [2:0]       rdy;
  logic [2:0]       bsy;
  logic [2:0]       err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   eq0[$];
  int   eq1[$];
  int   eq2[$];
  logic [15:0] model [3][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rdt[0]), .mem_ready(rdy[0]), .busy(bsy[0]), .req_err(err[0]));
  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rdt[1]), .mem_ready(rdy[1]), .busy(bsy[1]), .req_err(err[1]));
  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(4)) u_dut2 (
    .clk(clk), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]), .addr(ad[2]),
    .wdata(wd[2]), .rdata(rdt[2]), .mem_ready(rdy[2]), .busy(bsy[2]), .req_err(err[2]));

  function automatic int lat(input int i);
    case (i)
      0: return 2;
      1: return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", name, i, cyc, act, req);
    end
  endtask

  task automatic check_resp(input int i);
    exp_t e;
    bit   have = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready inst%0d cycle %0d: got pulse expected none", i, cyc);
    end else begin
      chk("ready_cycle", i, 16'(cyc), 16'(e.cyc));
      if (e.is_rd) chk("read_data", i, rdt[i], e.data);
    end
  endtask

  task automatic check_err(input int i);
    int c = -1;
    case (i)
      0: if (eq0.size() > 0) c = eq0.pop_front();
      1: if (eq1.size() > 0) c = eq1.pop_front();
      default: if (eq2.size() > 0) c = eq2.pop_front();
    endcase
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_req_err inst%0d cycle %0d: got pulse expected none", i, cyc);
    end else begin
      chk("req_err_cycle", i, 16'(cyc), 16'(c));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] === 1'b1) check_resp(i);
      if (err[i] === 1'b1) check_err(i);
    end
  end

  task automatic push_resp(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic push_err(input int i, input int c);
    case (i)
      0: eq0.push_back(c);
      1: eq1.push_back(c);
      default: eq2.push_back(c);
    endcase
  endtask

  // Drives a request at a negedge and holds it for 'hold' cycles; an aborted
  // request expects no response and leaves the model untouched.
  task automatic issue(input int i, input bit r, input bit w, input logic [7:0] a,
                       input logic [15:0] d, input int hold, input bit abort);
    exp_t e;
    int   acc;
    @(negedge clk);
    rd[i] = r;
    wr[i] = w;
    ad[i] = a;
    wd[i] = d;
    acc   = cyc;
    if (r && w) begin
      push_err(i, acc + 1);
    end else if (!abort) begin
      e.cyc   = acc + lat(i) + 1;
      e.is_rd = r;
      e.data  = r ? model[i][a] : d;
      push_resp(i, e);
      if (w) model[i][a] = d;
    end
    repeat (hold) @(negedge clk);
    rd[i] = 1'b0;
    wr[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rd = '0;
    wr = '0;
    ad = '0;
    wd = '0;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdata", i, rdt[i], 16'h0000);
      chk("reset_ready", i, 16'(rdy[i]), 16'h0);
      chk("reset_busy", i, 16'(bsy[i]), 16'h0);
      chk("reset_req_err", i, 16'(err[i]), 16'h0);
    end
    reset = 1'b0;

    // Write then read back the same word.
    issue(0, 1'b0, 1'b1, 8'h05, 16'h1234, 1, 1'b0);
    idle(4);
    issue(0, 1'b1, 1'b0, 8'h05, 16'h0000, 1, 1'b0);
    idle(4);

    // Read strobe held six cycles: one response, busy until the strobe is gone.
    issue(0, 1'b1, 1'b0, 8'h05, 16'h0000, 6, 1'b0);
    chk("busy_held", 0, 16'(bsy[0]), 16'h1);
    idle(1);
    chk("busy_released", 0, 16'(bsy[0]), 16'h0);
    idle(2);

    // Conflicting request: error pulse, no access.
    issue(0, 1'b0, 1'b1, 8'h07, 16'h5A5A, 1, 1'b0);
    idle(4);
    issue(0, 1'b1, 1'b1, 8'h07, 16'hFFFF, 1, 1'b0);
    idle(3);
    issue(0, 1'b1, 1'b0, 8'h07, 16'h0000, 1, 1'b0);
    idle(4);

    // Reset during the first ACCESS cycle aborts the write.
    issue(0, 1'b0, 1'b1, 8'h10, 16'h0A0A, 1, 1'b0);
    idle(4);
    issue(0, 1'b0, 1'b1, 8'h10, 16'hBEEF, 1, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("abort_busy", 0, 16'(bsy[0]), 16'h0);
    idle(2);
    issue(0, 1'b1, 1'b0, 8'h10, 16'h0000, 1, 1'b0);
    idle(4);

    // Read of 0xFF on every latency build with addr changed during ACCESS.
    for (int i = 0; i < 3; i++) begin
      issue(i, 1'b0, 1'b1, 8'hFF, 16'hC3C3 ^ 16'(i), 1, 1'b0);
      idle(lat(i) + 3);
      issue(i, 1'b0, 1'b1, 8'h00, 16'h1111, 1, 1'b0);
      idle(lat(i) + 3);
      issue(i, 1'b1, 1'b0, 8'hFF, 16'h0000, 1, 1'b0);
      ad[i] = 8'h00;
      idle(lat(i) + 3);
    end

    idle(8);
    checks++;
    if ((q0.size() + q1.size() + q2.size() + eq0.size() + eq1.size() + eq2.size()) != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d outstanding expected 0",
               q0.size() + q1.size() + q2.size() + eq0.size() + eq1.size() + eq2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port memory responder: the target side of the control unit's `mem_read`/`mem_write` strobes. It latches the MAR address and the write data on request, waits a fixed access latency, then performs the read or write and returns read data with a one-cycle `mem_ready` pulse. It sits between the control unit/MAR/MBR datapath and the instruction/data store, and it gives the CPU a defined completion handshake in place of assumed zero-latency memory.

## Interface
- `ADDR_W`, default 8: address width; the array depth is 2^ADDR_W words.
- `DATA_W`, default 16: word width.
- `LATENCY`, default 2: number of wait cycles between acceptance and access; legal range 1..15.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request (level).
- `mem_write`  in  1  write request (level).
- `addr`  in  ADDR_W  word address from MAR.
- `wdata`  in  DATA_W  write data from ACC/MBR.
- `rdata`  out  DATA_W  read data, registered; valid while `mem_ready` is high and held afterwards.
- `mem_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `req_err`  out  1  one-cycle pulse when `mem_read` and `mem_write` are both high at acceptance.

## Operation
- States: IDLE, ACCESS, RESPOND, WAIT_REL.
- IDLE: if `mem_read` or `mem_write` is high at a clock edge, the block latches `addr`, `wdata` and the request type, loads `wait_cnt = LATENCY-1`, and moves to ACCESS.
  - If both requests are high at that edge, nothing is latched and no access happens. `req_err` pulses next cycle and the state moves to WAIT_REL.
- ACCESS: `wait_cnt` decrements once per cycle. At the edge where `wait_cnt == 0`:
  - read: the array word at the latched address is registered into `rdata`;
  - write: the latched `wdata` is written to the array; `rdata` is unchanged.
  - The state moves to RESPOND.
- RESPOND: `mem_ready` is high for exactly this cycle. At the next edge the state moves to WAIT_REL if either request is still high, otherwise to IDLE.
- WAIT_REL: the block waits until both requests are low, then returns to IDLE. This rule prevents a held strobe from being serviced twice.
- Requests and changes on `addr`/`wdata` outside IDLE are ignored; the latched values are used.
- Address arithmetic is plain ADDR_W-bit indexing. There are no out-of-range addresses and no wrap logic.

## Timing
- Reset values: state IDLE, `rdata = 0`, `mem_ready = 0`, `busy = 0`, `req_err = 0`, `wait_cnt = 0`.
- Reset does not clear the array contents.
- Reset asserted in ACCESS aborts the operation. A pending write is not committed, because the write happens only at the final ACCESS edge.
- Latency: with the request high in cycle 0 (IDLE), `mem_ready` is high in cycle LATENCY+1. For LATENCY=2 that is cycle 3. `busy` is high from cycle 1 through the RESPOND cycle, plus any WAIT_REL cycles.
- Minimum spacing between back-to-back accepted requests is LATENCY+2 cycles, when the request is dropped before RESPOND.
- Read-after-write to the same address returns the new data, because the write commits before the next acceptance is possible.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE=0, ACCESS=1, RESPOND=2, WAIT_REL=3);
  - the default `ADDR_W`, `DATA_W` and `LATENCY` constants, reused by the control unit and datapath.
- Sub-module `mem_array`: synchronous single-port RAM with registered read and a write enable, 2^ADDR_W x DATA_W.
- The FSM, counter and latches stay in `mem_responder`.

## Test plan
- Reset, then a write of 0x1234 to address 0x05 held for 1 cycle, then a read of address 0x05 → `mem_ready` pulses in cycle 3 of each request; the read returns `rdata = 0x1234`.
- `mem_read` held high for 6 cycles on address 0x05 → exactly one `mem_ready` pulse; `busy` stays high until the cycle after `mem_read` falls.
- `mem_read` and `mem_write` both high on address 0x07 with `wdata = 0xFFFF` → `req_err` pulses one cycle, no `mem_ready`, address 0x07 unchanged on readback.
- Write of 0xBEEF to address 0x10, with `reset` pulsed during the first ACCESS cycle → state returns to IDLE, no `mem_ready`, address 0x10 keeps its old value.
- LATENCY=1 and LATENCY=4 builds with a read of address 0xFF → `mem_ready` arrives in cycle 2 and cycle 5 respectively. Changing `addr` during ACCESS does not affect the returned data.
